// File: rtl/l1_cache_responder_if.sv
// Processor ce/rw/addr/RDY bus plus the L2 req/ack initiator bus of the L1 cache.
// slave is the cache's view; master is the environment's (processor and L2).
interface l1_cache_responder_if;
  logic        ce;
  logic        rw;
  logic [23:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        RDY;
  logic        l2_req;
  logic        l2_rw;
  logic [23:0] l2_addr;
  logic [7:0]  l2_wdata;
  logic [7:0]  l2_rdata;
  logic        l2_ack;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  modport slave (
    input  ce, rw, addr, data_in, l2_rdata, l2_ack,
    output data_out, RDY, l2_req, l2_rw, l2_addr, l2_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output ce, rw, addr, data_in, l2_rdata, l2_ack,
    input  data_out, RDY, l2_req, l2_rw, l2_addr, l2_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/l1_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate L1 cache with one-byte lines.
// Read hits are served locally; read misses and all writes go through the L2 port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for ce; request registers load on the accepting edge
// S_LOOKUP  | tag compare; read hit answers locally, otherwise issue to L2
// S_L2_WAIT | L2 request held stable until l2_ack is sampled
// S_RESP    | RDY is driven high on the edge leaving this state
// S_RELEASE | RDY high this cycle, falls on exit; ce is ignored here
module l1_cache_responder #(
  parameter  int INDEX_BITS = 6,
  localparam int TAG_BITS   = 24 - INDEX_BITS
) (
  input logic               clk,
  input logic               rst_n,
  l1_cache_responder_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_L2_WAIT, S_RESP, S_RELEASE
  } state_e;

  state_e                state_q, state_d;
  logic [23:0]           req_addr_q, req_addr_d;
  logic                  req_rw_q, req_rw_d;
  logic [7:0]            req_data_q, req_data_d;
  logic [7:0]            data_out_q, data_out_d;
  logic                  rdy_q, rdy_d;
  logic                  l2_req_q, l2_req_d;
  logic                  l2_rw_q, l2_rw_d;
  logic [23:0]           l2_addr_q, l2_addr_d;
  logic [7:0]            l2_wdata_q, l2_wdata_d;
  logic [15:0]           hit_cnt_q, hit_cnt_d;
  logic [15:0]           miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [7:0]            data_q [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic                  line_we;
  logic [7:0]            line_wdata;

  assign req_idx = req_addr_q[INDEX_BITS-1:0];
  assign req_tag = req_addr_q[23:INDEX_BITS];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_rw_d   = req_rw_q;
    req_data_d = req_data_q;
    data_out_d = data_out_q;
    rdy_d      = (state_q == S_RESP);
    l2_req_d   = l2_req_q;
    l2_rw_d    = l2_rw_q;
    l2_addr_d  = l2_addr_q;
    l2_wdata_d = l2_wdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    line_we    = 1'b0;
    line_wdata = req_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ce) begin
          req_addr_d = bus.addr;
          req_rw_d   = bus.rw;
          req_data_d = bus.data_in;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (req_rw_q && hit) begin
          data_out_d = data_q[req_idx];
          hit_cnt_d  = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
          state_d    = S_RESP;
        end else begin
          if (req_rw_q) begin
            miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
          end else begin
            l2_wdata_d = req_data_q;
            // Write hit updates the line in place; a write miss does not allocate.
            line_we    = hit;
          end
          l2_req_d  = 1'b1;
          l2_rw_d   = req_rw_q;
          l2_addr_d = req_addr_q;
          state_d   = S_L2_WAIT;
        end
      end
      S_L2_WAIT: begin
        if (bus.l2_ack) begin
          l2_req_d = 1'b0;
          if (req_rw_q) begin
            valid_d[req_idx] = 1'b1;
            line_we          = 1'b1;
            line_wdata       = bus.l2_rdata;
            data_out_d       = bus.l2_rdata;
          end
          state_d = S_RESP;
        end
      end
      S_RESP:    state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_rw_q   <= 1'b0;
      req_data_q <= '0;
      data_out_q <= '0;
      rdy_q      <= 1'b0;
      l2_req_q   <= 1'b0;
      l2_rw_q    <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_rw_q   <= req_rw_d;
      req_data_q <= req_data_d;
      data_out_q <= data_out_d;
      rdy_q      <= rdy_d;
      l2_req_q   <= l2_req_d;
      l2_rw_q    <= l2_rw_d;
      l2_addr_q  <= l2_addr_d;
      l2_wdata_q <= l2_wdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Tag and data storage need no reset: the valid bits guard them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= line_wdata;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.RDY      = rdy_q;
  assign bus.l2_req   = l2_req_q;
  assign bus.l2_rw    = l2_rw_q;
  assign bus.l2_addr  = l2_addr_q;
  assign bus.l2_wdata = l2_wdata_q;
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_l1_cache_responder.sv
// Directed-vector bench for l1_cache_responder with a behavioural L2 responder
// and a processor that holds ce until RDY, then re-raises it after RDY falls.
module tb_l1_cache_responder;
  logic clk;
  logic rst_n;
  l1_cache_responder_if bus ();

  l1_cache_responder #(.INDEX_BITS(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int rdy_total = 0;

  // L2 responder state
  int          l2_delay = 1;
  int          l2_cnt = 0;
  int          l2_cycles = 0;
  bit          l2_unstable = 0;
  logic [23:0] seen_addr;
  logic        seen_rw;
  logic [7:0]  seen_wdata;
  logic [23:0] first_addr;
  logic        first_rw;
  logic [7:0]  first_wdata;
  logic [7:0]  l2_mem [logic [23:0]];

  function automatic logic [7:0] l2_read(input logic [23:0] a);
    if (l2_mem.exists(a)) return l2_mem[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (bus.RDY === 1'b1) rdy_total++;

  initial begin
    bus.l2_ack   = 1'b0;
    bus.l2_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.l2_ack   = 1'b0;
      bus.l2_rdata = 8'($urandom);
      if (bus.l2_req === 1'b1) begin
        if (l2_cnt == 0) begin
          first_addr  = bus.l2_addr;
          first_rw    = bus.l2_rw;
          first_wdata = bus.l2_wdata;
        end else if (bus.l2_addr !== first_addr || bus.l2_rw !== first_rw ||
                     (!first_rw && bus.l2_wdata !== first_wdata)) begin
          l2_unstable = 1;
        end
        l2_cycles++;
        l2_cnt++;
        if (l2_cnt >= l2_delay) begin
          seen_addr  = bus.l2_addr;
          seen_rw    = bus.l2_rw;
          seen_wdata = bus.l2_wdata;
          if (bus.l2_rw) bus.l2_rdata = l2_read(bus.l2_addr);
          else           l2_mem[bus.l2_addr] = bus.l2_wdata;
          bus.l2_ack = 1'b1;
          l2_cnt     = 0;
        end
      end else begin
        l2_cnt = 0;
      end
    end
  end

  // One processor transaction; returns #1 after the edge on which RDY falls.
  task automatic xact(input logic r, input logic [23:0] a, input logic [7:0] d,
                      input int dly, input bit keep,
                      output logic [7:0] dout, output int lat);
    l2_delay    = dly;
    l2_cycles   = 0;
    l2_unstable = 0;
    seen_addr   = '0;
    seen_rw     = 1'bx;
    seen_wdata  = '0;
    bus.ce      = 1'b1;
    bus.rw      = r;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk); #1;
    bus.ce      = keep;
    bus.rw      = ~r;
    bus.addr    = ~a;
    bus.data_in = ~d;
    lat = 0;
    while (lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (bus.RDY === 1'b1) break;
    end
    chk("rdy_seen", 32'(bus.RDY), 32'd1);
    dout = bus.data_out;
    @(posedge clk); #1;
    chk("rdy_width", 32'(bus.RDY), 32'd0);
  endtask

  typedef struct {
    logic        rw;
    logic [23:0] addr;
    logic [7:0]  wdata;
    int          delay;
    logic        exp_hit;
    logic [7:0]  exp_dout;
    logic [15:0] exp_hits;
    logic [15:0] exp_miss;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [7:0]  dout;
    int          lat;
    logic        mv [64];
    logic [17:0] mt [64];
    int          reads, hits, misses;

    vecs[0]  = '{1'b1, 24'h123440, 8'h00, 3, 1'b0, 8'hA5, 16'd0, 16'd1};
    vecs[1]  = '{1'b1, 24'h123440, 8'h00, 1, 1'b1, 8'hA5, 16'd1, 16'd1};
    vecs[2]  = '{1'b0, 24'h123440, 8'h3C, 2, 1'b0, 8'hA5, 16'd1, 16'd1};
    vecs[3]  = '{1'b1, 24'h123440, 8'h00, 1, 1'b1, 8'h3C, 16'd2, 16'd1};
    vecs[4]  = '{1'b0, 24'h000080, 8'h77, 1, 1'b0, 8'h3C, 16'd2, 16'd1};
    vecs[5]  = '{1'b1, 24'h000080, 8'h00, 2, 1'b0, 8'h77, 16'd2, 16'd2};
    vecs[6]  = '{1'b1, 24'h001080, 8'h00, 1, 1'b0, 8'hCA, 16'd2, 16'd3};
    vecs[7]  = '{1'b1, 24'h000080, 8'h00, 4, 1'b0, 8'h77, 16'd2, 16'd4};
    vecs[8]  = '{1'b1, 24'h000080, 8'h00, 1, 1'b1, 8'h77, 16'd3, 16'd4};
    vecs[9]  = '{1'b1, 24'h001080, 8'h00, 1, 1'b0, 8'hCA, 16'd3, 16'd5};
    vecs[10] = '{1'b0, 24'h00003F, 8'h11, 1, 1'b0, 8'hCA, 16'd3, 16'd5};
    vecs[11] = '{1'b1, 24'hFFFFFF, 8'h00, 1, 1'b0, 8'hA5, 16'd3, 16'd6};
    vecs[12] = '{1'b1, 24'hFFFFFF, 8'h00, 1, 1'b1, 8'hA5, 16'd4, 16'd6};
    vecs[13] = '{1'b1, 24'h00003F, 8'h00, 2, 1'b0, 8'h11, 16'd4, 16'd7};
    l2_mem[24'h123440] = 8'hA5;

    rst_n = 1'b0;
    bus.ce = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("rst_rdy",      32'(bus.RDY),      32'd0);
    chk("rst_l2_req",   32'(bus.l2_req),   32'd0);
    chk("rst_hit_cnt",  32'(bus.hit_cnt),  32'd0);
    chk("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);

    // Reset in the middle of an L2 wait aborts with no RDY and no fill.
    l2_delay = 20;
    @(negedge clk);
    bus.ce = 1'b1; bus.rw = 1'b1; bus.addr = 24'h000200;
    @(posedge clk); #1 bus.ce = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("midwait_l2_req", 32'(bus.l2_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("abort_l2_req", 32'(bus.l2_req), 32'd0);
    chk("abort_rdy", 32'(bus.RDY), 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_rdy",  32'(rdy_total),    32'd0);
    chk("abort_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    @(posedge clk); #1;
    xact(1'b1, 24'h000010, 8'h00, 2, 1'b0, dout, lat);
    chk("post_rst_data", 32'(dout),         32'h4A);
    chk("post_rst_miss", 32'(bus.miss_cnt), 32'd1);
    chk("post_rst_hit",  32'(bus.hit_cnt),  32'd0);

    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      xact(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].delay, 1'b0, dout, lat);
      if (vecs[i].exp_hit) begin
        chk($sformatf("v%0d_lat", i),       32'(lat),       32'd2);
        chk($sformatf("v%0d_l2_quiet", i),  32'(l2_cycles), 32'd0);
      end else begin
        chk($sformatf("v%0d_lat", i),       32'(lat),       32'(2 + vecs[i].delay));
        chk($sformatf("v%0d_l2_cycles", i), 32'(l2_cycles), 32'(vecs[i].delay));
        chk($sformatf("v%0d_l2_addr", i),   32'(seen_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_l2_rw", i),     32'(seen_rw),   32'(vecs[i].rw));
        chk($sformatf("v%0d_l2_stable", i), 32'(l2_unstable), 32'd0);
        if (!vecs[i].rw)
          chk($sformatf("v%0d_l2_wdata", i), 32'(seen_wdata), 32'(vecs[i].wdata));
      end
      chk($sformatf("v%0d_data_out", i), 32'(dout),         32'(vecs[i].exp_dout));
      chk($sformatf("v%0d_hit_cnt", i),  32'(bus.hit_cnt),  32'(vecs[i].exp_hits));
      chk($sformatf("v%0d_miss_cnt", i), 32'(bus.miss_cnt), 32'(vecs[i].exp_miss));
    end

    // Back-to-back handshake: ce stays high through RELEASE and is reloaded after RDY falls.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) mv[k] = 1'b0;
    reads = 0; hits = 0; misses = 0;
    for (int n = 0; n < 256; n++) begin
      logic        r;
      logic [5:0]  idx;
      logic [17:0] tag;
      logic [23:0] a;
      logic [7:0]  d, exp_d;
      int          dly;
      bit          h;
      r   = ($urandom_range(0, 9) < 7);
      idx = 6'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       tag = 18'h00000;
        1:       tag = 18'h2AAAA;
        default: tag = 18'h3FFFF;
      endcase
      a     = {tag, idx};
      d     = 8'($urandom);
      dly   = $urandom_range(1, 3);
      h     = r && mv[idx] && (mt[idx] == tag);
      exp_d = l2_read(a);
      xact(r, a, d, dly, 1'b1, dout, lat);
      chk($sformatf("hs%0d_lat", n), 32'(lat), h ? 32'd2 : 32'(2 + dly));
      if (r) begin
        reads++;
        chk($sformatf("hs%0d_data", n), 32'(dout), 32'(exp_d));
        if (h) hits++;
        else begin
          misses++;
          mv[idx] = 1'b1;
          mt[idx] = tag;
        end
      end
    end
    bus.ce = 1'b0;
    chk("hs_hit_cnt",    32'(bus.hit_cnt),  32'(hits));
    chk("hs_miss_cnt",   32'(bus.miss_cnt), 32'(misses));
    chk("hs_read_total", 32'(bus.hit_cnt) + 32'(bus.miss_cnt), 32'(reads));
    repeat (3) @(negedge clk);
    chk("rdy_pulse_total", 32'(rdy_total), 32'd271);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/l1_cache_responder.md
Name: l1_cache_responder

Overview:
- Direct-mapped, write-through L1 cache that is the responder for the processor's ce/rw/addr/RDY memory interface.
- Serves read hits locally and forwards misses and all writes to the L2 level through a req/ack initiator port.
- Answers every processor transaction with a single-cycle RDY pulse.
- Keeps saturating hit/miss counters for performance tests.

Parameters:
- INDEX_BITS, 6, line-index width; 2**INDEX_BITS one-byte lines.
- TAG_BITS, 24-INDEX_BITS, stored tag width (derived; do not override).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  processor request strobe
- rw  in  1  1=read, 0=write
- addr  in  24  processor byte address
- data_in  in  8  processor write data
- data_out  out  8  read data returned to processor
- RDY  out  1  one-cycle completion pulse
- l2_req  out  1  request to L2
- l2_rw  out  1  1=read, 0=write to L2
- l2_addr  out  24  L2 address
- l2_wdata  out  8  L2 write data
- l2_rdata  in  8  L2 read data, valid with l2_ack
- l2_ack  in  1  L2 completion, one cycle
- hit_cnt  out  16  read-hit count, saturates at 16'hFFFF
- miss_cnt  out  16  read-miss count, saturates at 16'hFFFF

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All valid bits cleared.
  - data_out, RDY, l2_req, l2_rw, l2_addr, l2_wdata, hit_cnt, miss_cnt all 0.
- Address split:
  - index=addr[INDEX_BITS-1:0]
  - tag=addr[23:INDEX_BITS]
  - Per line: valid bit, TAG_BITS tag, 8-bit data.
- IDLE:
  - ce=1 at an edge captures addr, rw, data_in into request registers (acceptance edge A); go LOOKUP.
  - Processor inputs are not used after A.
- LOOKUP (edge A+1), hit = valid[index] && tag match:
  - Read hit: data_out<=line data, hit_cnt++, go RESP.
  - Read miss: miss_cnt++; l2_req<=1, l2_rw<=1, l2_addr<=req addr; go L2_WAIT.
  - Write (hit or miss): l2_req<=1, l2_rw<=0, l2_addr, l2_wdata<=req data; go L2_WAIT.
    - On hit, line data<=req data in the same edge.
    - On miss, no allocate.
- L2_WAIT:
  - l2_req, l2_rw, l2_addr, l2_wdata held stable until the edge sampling l2_ack=1.
  - At that edge l2_req<=0.
  - On a read: line fill (valid=1, tag, data<=l2_rdata) and data_out<=l2_rdata.
  - Go RESP.
  - l2_ack seen in any other state is ignored.
  - No timeout.
- RESP: RDY=1 for exactly one cycle; go RELEASE.
- RELEASE: RDY=0 for one cycle; go IDLE, ignoring ce. This absorbs the processor's ce drop/re-raise after RDY falls.
- Latency, acceptance edge to RDY high:
  - Read hit: 2 cycles.
  - Miss or write: 2 + L2 wait cycles.
  - Back-to-back request accepted no earlier than 2 cycles after RDY rises.
- data_out holds its value from RESP until the next read updates it; writes leave it unchanged.
- Counters saturate at 16'hFFFF, do not wrap, and are incremented only in LOOKUP.
- Reset mid-transaction aborts immediately:
  - l2_req drops.
  - Any pending fill is discarded.
  - No RDY is produced.
- Index aliasing: a read miss replaces the resident line unconditionally. Write-through means no writeback is needed.

Test Plan:
- Reset: hold rst_n=0 mid-L2_WAIT, release -> RDY=0, l2_req=0, counters 0; then read 0x000010 misses (miss_cnt=1).
- Cold read miss: read 0x123440, L2 acks after 3 cycles with 8'hA5 -> l2_req high 3 cycles with l2_addr=0x123440, l2_rw=1; data_out=8'hA5; one RDY pulse; miss_cnt=1.
- Read hit: repeat read 0x123440 -> no l2_req; RDY exactly 2 cycles after acceptance; data_out=8'hA5; hit_cnt=1.
- Write hit: write 8'h3C to 0x123440 -> l2_req with l2_rw=0, l2_wdata=8'h3C; RDY after ack; following read of 0x123440 hits with data_out=8'h3C.
- Write miss (no allocate) and conflict:
  - Write 8'h77 to 0x000080 -> L2 write issued.
  - Read 0x000080 -> misses.
  - Read 0x001080 (same index, INDEX_BITS=6) -> miss evicts the line.
  - Re-read 0x000080 -> misses again (miss_cnt += 3).
- Processor handshake: drive the ce/RDY sequence of 256 mixed requests with ce re-raised on the edge after RDY falls -> each request gets exactly one RDY pulse, none duplicated or dropped; hit_cnt+miss_cnt equals the read count.
